// File: rtl/fft8_in_buf.sv
// fft8_in_buf: ping-pong input loader that scatters samples into bit-reversed lanes for the 8-point FFT
module fft8_in_buf #(
  parameter int FFT_DATA_WD = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_vld,
  input  logic                     din_sop,
  input  logic [FFT_DATA_WD-1:0]   din_re,
  input  logic [FFT_DATA_WD-1:0]   din_im,
  output logic                     din_rdy,
  input  logic                     out_rdy,
  output logic                     vld_out,
  output logic [8*FFT_DATA_WD-1:0] fft_dout_re,
  output logic [8*FFT_DATA_WD-1:0] fft_dout_im,
  output logic                     sop_err
);
  logic [2:0] cnt, idx, lane;
  logic wr_bank, rd_bank, accept, xfer;
  logic [1:0] full;
  logic [FFT_DATA_WD-1:0] bank_re [2][8];
  logic [FFT_DATA_WD-1:0] bank_im [2][8];
  always_comb begin
    idx = din_sop ? 3'd0 : cnt;
    lane = {idx[0], idx[1], idx[2]};
  end
  assign din_rdy = !rst && !full[wr_bank];
  assign accept = din_vld && din_rdy;
  assign vld_out = full[rd_bank];
  assign xfer = vld_out && out_rdy;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 3'd0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full <= 2'b00;
      sop_err <= 1'b0;
      for (int b = 0; b < 2; b++)
        for (int l = 0; l < 8; l++) begin
          bank_re[b][l] <= '0;
          bank_im[b][l] <= '0;
        end
    end else begin
      sop_err <= accept && din_sop && cnt != 3'd0;
      if (xfer) begin
        full[rd_bank] <= 1'b0;
        rd_bank <= !rd_bank;
      end
      if (accept) begin
        bank_re[wr_bank][lane] <= din_re;
        bank_im[wr_bank][lane] <= din_im;
        cnt <= idx + 3'd1;
        if (idx == 3'd7) begin
          full[wr_bank] <= 1'b1;
          wr_bank <= !wr_bank;
        end
      end
    end
  end
  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign fft_dout_re[k*FFT_DATA_WD +: FFT_DATA_WD] = bank_re[rd_bank][k];
    assign fft_dout_im[k*FFT_DATA_WD +: FFT_DATA_WD] = bank_im[rd_bank][k];
  end
endmodule
